j17_ctrl: RTL

- Multi-cycle fetch/decode/sequencing controller for the J17 core.
- Sits on the control side of the DP datapath: fetches a 32-bit instruction from instruction memory at the datapath PC, decodes it, and drives DP's control inputs (alucode, op1, op2, imControl, flag, flag1, regenable, ramenable, pcControl, writecode).
- Gates PC advance with a one-cycle pc_enable strobe per retired instruction; the DP revision paired with this block advances PC only on that strobe.

---
 rtl/j17_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/j17_ctrl.sv
// J17 fetch/decode/sequencing controller: fetches at the DP PC, decodes and drives DP controls.
// Optional macro J17_CTRL_PERF_EN adds retired_cnt / cycle_cnt performance counters.
module j17_ctrl #(
    parameter int unsigned IMEM_AW       = 10,
    parameter int unsigned MEM_WAIT      = 1,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [31:0]        pc,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_valid,
    input  logic [31:0]        imem_rdata,
    output logic [4:0]         alucode,
    output logic [2:0]         op1,
    output logic [20:0]        op2,
    output logic               imControl,
    output logic               flag,
    output logic               flag1,
    output logic               regenable,
    output logic [1:0]         ramenable,
    output logic [2:0]         pcControl,
    output logic [1:0]         writecode,
    output logic               pc_enable,
    output logic               halted,
`ifdef J17_CTRL_PERF_EN
    output logic               fault,
    output logic [31:0]        retired_cnt,
    output logic [31:0]        cycle_cnt
`else
    output logic               fault
`endif
);

    localparam int unsigned TmoW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(FETCH_TIMEOUT - 1);
    localparam logic [2:0] WaitLast = 3'(MEM_WAIT);

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StWb, StHalt} state_e;

    state_e          state_q, state_d;
    logic [31:0]     ir_q;
    logic            fault_q, fault_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [2:0]      wait_q, wait_d;

    logic [4:0] opc;
    logic [4:0] br_sel;
    logic       is_alu, is_mov, is_store, is_br, is_halt, is_legal, uses_ram;

    assign opc      = ir_q[31:27];
    assign br_sel   = opc - 5'd13;
    assign is_alu   = (opc <= 5'd11);
    assign is_mov   = (opc == 5'd12);
    assign is_store = (opc == 5'd13);
    assign is_br    = (opc >= 5'd14) && (opc <= 5'd20);
    assign is_halt  = (opc == 5'd31);
    // Legal non-halting opcodes occupy 0..21 contiguously.
    assign is_legal = (opc <= 5'd21);
    assign uses_ram = ir_q[25] | ir_q[24];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            ir_q    <= '0;
            fault_q <= 1'b0;
            tmo_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            tmo_q   <= tmo_d;
            wait_q  <= wait_d;
            if (state_q == StFetch && imem_valid) begin
                ir_q <= imem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        tmo_d   = tmo_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                tmo_d   = '0;
            end
            StFetch: begin
                if (imem_valid) begin
                    state_d = StDecode;
                end else if (tmo_q == TmoLast) begin
                    state_d = StHalt;
                    fault_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDecode: begin
                wait_d = '0;
                if (is_halt) begin
                    state_d = StHalt;
                end else if (!is_legal) begin
                    state_d = StHalt;
                    fault_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                // RAM-operand instructions hold EXEC until the read data has settled.
                if (uses_ram && wait_q != WaitLast) begin
                    wait_d = wait_q + 1'b1;
                end else begin
                    state_d = StWb;
                end
            end
            StWb: begin
                state_d = StFetch;
                tmo_d   = '0;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        alucode   = 5'd21;
        op1       = '0;
        op2       = '0;
        imControl = 1'b0;
        flag      = 1'b0;
        flag1     = 1'b0;
        regenable = 1'b0;
        ramenable = 2'b00;
        pcControl = '0;
        writecode = 2'b00;
        pc_enable = 1'b0;
        halted    = 1'b0;
        fault     = fault_q;
        unique case (state_q)
            StFetch: begin
                imem_req  = 1'b1;
                imem_addr = pc[IMEM_AW-1:0];
            end
            StDecode, StExec, StWb: begin
                if (is_legal) begin
                    op1       = ir_q[23:21];
                    op2       = ir_q[20:0];
                    imControl = ir_q[26];
                    flag      = ir_q[25];
                    flag1     = ir_q[24];
                    if (is_alu) alucode = opc;
                    if (is_br) pcControl = br_sel[2:0];
                    if (is_mov) writecode = 2'd1;
                    if (state_q == StWb) begin
                        pc_enable = 1'b1;
                        regenable = is_alu | is_mov;
                        if (is_store) ramenable = 2'b01;
                    end
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

`ifdef J17_CTRL_PERF_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            retired_cnt <= '0;
            cycle_cnt   <= '0;
        end else begin
            if (pc_enable) retired_cnt <= retired_cnt + 32'd1;
            if (state_q != StHalt) cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule
